// File: rtl/hazard_stall_if.sv
// hazard_stall_if
//   Groups the hazard/stall controller's pipeline-facing signals.
//   master : pipeline side. It drives the ID/EX/MEM status and receives the stall controls.
//   slave  : hazard_stall_unit side.
//   Pipeline status : valid_id, rs_id, rt_id, use_rs_id, use_rt_id, memread_ex,
//                     dest_ex, branch_taken_ex, mem_busy
//   Controls        : pc_write_en, ifid_write_en, ifid_flush, idex_bubble, pipe_hold,
//                     mem_timeout_err, stall_cycles, flush_count
interface hazard_stall_if #(
  parameter int CNT_W = 32
);
  logic             valid_id;
  logic [4:0]       rs_id;
  logic [4:0]       rt_id;
  logic             use_rs_id;
  logic             use_rt_id;
  logic             memread_ex;
  logic [4:0]       dest_ex;
  logic             branch_taken_ex;
  logic             mem_busy;
  logic             pc_write_en;
  logic             ifid_write_en;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             pipe_hold;
  logic             mem_timeout_err;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output valid_id, rs_id, rt_id, use_rs_id, use_rt_id, memread_ex, dest_ex,
           branch_taken_ex, mem_busy,
    input  pc_write_en, ifid_write_en, ifid_flush, idex_bubble, pipe_hold,
           mem_timeout_err, stall_cycles, flush_count
  );

  modport slave (
    input  valid_id, rs_id, rt_id, use_rs_id, use_rt_id, memread_ex, dest_ex,
           branch_taken_ex, mem_busy,
    output pc_write_en, ifid_write_en, ifid_flush, idex_bubble, pipe_hold,
           mem_timeout_err, stall_cycles, flush_count
  );
endinterface

// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit
//   Pipeline hazard and stall controller for the 5-stage MIPS core.
//   - Load-use hazards: freezes PC and IF/ID, and bubbles ID/EX once or twice (LOAD_BUBBLES).
//   - Taken branches in EX: flushes IF/ID and bubbles ID/EX.
//   - Data-memory wait: holds the back end. A sticky error is raised after MEM_TIMEOUT busy cycles.
//   Ports:
//     clk : rising-edge clock
//     rst : asynchronous active-low reset. While it is low, all controls are forced low.
//     hz  : hazard_stall_if.slave, which carries the pipeline status in and the controls out.
//   Controls are Mealy outputs computed from the state and the current inputs.
//   Optional feature macro HAZARD_STATS_EN:
//     When defined, stall_cycles and flush_count are saturating counters.
//     When undefined, both ports are tied to zero.
module hazard_stall_unit #(
  parameter int LOAD_BUBBLES = 1,
  parameter int MEM_TIMEOUT  = 255,
  parameter int CNT_W        = 32
) (
  input logic           clk,
  input logic           rst,
  hazard_stall_if.slave hz
);
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  localparam logic        TWO_BUBBLES = (LOAD_BUBBLES == 2);
  localparam logic [15:0] WAIT_LAST   = 16'(MEM_TIMEOUT - 1);

  state_t      state_r;
  state_t      state_nxt_s;
  state_t      ret_state_r;
  state_t      ret_nxt_s;
  state_t      eval_state_s;
  logic [15:0] wait_cnt_r;
  logic        err_r;
  logic        lu_hit_s;
  logic        pc_we_s;
  logic        ifid_we_s;
  logic        flush_s;
  logic        bubble_s;
  logic        hold_s;

  // load-use hazard: the ID instruction reads the register that the load in EX writes
  always_comb begin
    lu_hit_s = hz.valid_id & hz.memread_ex & (hz.dest_ex != 5'd0) &
               ((hz.use_rs_id & (hz.rs_id == hz.dest_ex)) |
                (hz.use_rt_id & (hz.rt_id == hz.dest_ex)));
  end

  // rules in force this cycle: the cycle memory becomes ready behaves like the saved state
  always_comb begin
    if ((state_r == MEM_WAIT) && !hz.mem_busy) begin
      eval_state_s = ret_state_r;
    end else begin
      eval_state_s = state_r;
    end
  end

  // next-state and control outputs
  always_comb begin
    pc_we_s     = 1'b1;
    ifid_we_s   = 1'b1;
    flush_s     = 1'b0;
    bubble_s    = 1'b0;
    hold_s      = 1'b0;
    state_nxt_s = state_r;
    ret_nxt_s   = ret_state_r;
    if (!rst) begin
      pc_we_s   = 1'b0;
      ifid_we_s = 1'b0;
    end else if (hz.mem_busy) begin
      hold_s      = 1'b1;
      pc_we_s     = 1'b0;
      ifid_we_s   = 1'b0;
      state_nxt_s = MEM_WAIT;
      // remember where to resume only on entry, so repeated busy cycles keep it
      if (state_r != MEM_WAIT) begin
        ret_nxt_s = state_r;
      end else begin
        ret_nxt_s = ret_state_r;
      end
    end else begin
      case (eval_state_s)
        LU_STALL: begin
          // second bubble; EX holds a bubble, so a branch indication here is stale
          pc_we_s     = 1'b0;
          ifid_we_s   = 1'b0;
          bubble_s    = 1'b1;
          state_nxt_s = RUN;
        end
        RUN: begin
          state_nxt_s = RUN;
          if (hz.branch_taken_ex) begin
            flush_s  = 1'b1;
            bubble_s = 1'b1;
          end else if (lu_hit_s) begin
            pc_we_s   = 1'b0;
            ifid_we_s = 1'b0;
            bubble_s  = 1'b1;
            if (TWO_BUBBLES) begin
              state_nxt_s = LU_STALL;
            end else begin
              state_nxt_s = RUN;
            end
          end else begin
            state_nxt_s = RUN;
          end
        end
        default: begin
          state_nxt_s = RUN;
        end
      endcase
    end
  end

  // state registers, busy-cycle counter and sticky timeout flag.
  // wait_cnt counts consecutive busy edges, including the entry edge. The flag therefore
  // sets on the MEM_TIMEOUT-th busy edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= RUN;
      ret_state_r <= RUN;
      wait_cnt_r  <= 16'd0;
      err_r       <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      ret_state_r <= ret_nxt_s;
      if (hz.mem_busy) begin
        if (wait_cnt_r != 16'hFFFF) begin
          wait_cnt_r <= wait_cnt_r + 16'd1;
        end else begin
          wait_cnt_r <= wait_cnt_r;
        end
        if (wait_cnt_r == WAIT_LAST) begin
          err_r <= 1'b1;
        end else begin
          err_r <= err_r;
        end
      end else begin
        wait_cnt_r <= 16'd0;
        err_r      <= err_r;
      end
    end
  end

  assign hz.pc_write_en     = pc_we_s;
  assign hz.ifid_write_en   = ifid_we_s;
  assign hz.ifid_flush      = flush_s;
  assign hz.idex_bubble     = bubble_s;
  assign hz.pipe_hold       = hold_s;
  assign hz.mem_timeout_err = err_r;

`ifdef HAZARD_STATS_EN
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] stall_cnt_r;
  logic [CNT_W-1:0] flush_cnt_r;

  // saturating statistics counters; pc_we_s is already low in reset, so only live cycles count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_r <= '0;
      flush_cnt_r <= '0;
    end else begin
      if (!pc_we_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
        stall_cnt_r <= stall_cnt_r + CNT_ONE;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (flush_s && (flush_cnt_r != {CNT_W{1'b1}})) begin
        flush_cnt_r <= flush_cnt_r + CNT_ONE;
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

  assign hz.stall_cycles = stall_cnt_r;
  assign hz.flush_count  = flush_cnt_r;
`else
  assign hz.stall_cycles = '0;
  assign hz.flush_count  = '0;
`endif
endmodule
